// File: rtl/serial_byte_adder_pkg.sv
// Shared types and constants for the serial byte adder.
// State encoding, byte width and index sizing helper.
package serial_byte_adder_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Byte index width; never below one bit.
   function automatic int idx_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/serial_byte_adder_stage.sv
// Combinational 8-bit add stage with carry in and out.
// Shared by all byte steps of the serial adder.
module byte_add_stage
   import serial_byte_adder_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] s,
   output logic              cout
);

   logic [BYTE_W:0] sum9;

   // Nine-bit sum keeps the carry out of the byte.
   always_comb begin
      sum9 = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
   end

   assign s    = sum9[BYTE_W-1:0];
   assign cout = sum9[BYTE_W];

endmodule

// File: rtl/serial_byte_adder.sv
// Wide adder sequencing operands LSB byte first through one byte stage.
// Start/done handshake; result registers hold until the next completion.
module serial_byte_adder
   import serial_byte_adder_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [BYTE_W*NBYTES-1:0] op_a,
   input  logic [BYTE_W*NBYTES-1:0] op_b,
   input  logic                     carry_in,
   output logic                     busy,
   output logic                     done,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     carry_out,
   output logic                     overflow
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int PW = W - BYTE_W;
   localparam int IW = idx_width(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   state_t state, state_nxt;

   logic [W-1:0]      a_sh;
   logic [W-1:0]      b_sh;
   logic [PW-1:0]     part;
   logic [W-1:0]      part_nxt;
   logic [IW-1:0]     idx;
   logic              carry_r;
   logic              a_msb;
   logic              b_msb;
   logic [BYTE_W-1:0] st_s;
   logic              st_cout;
   logic              last;

   byte_add_stage u_stage (
      .a    (a_sh[BYTE_W-1:0]),
      .b    (b_sh[BYTE_W-1:0]),
      .cin  (carry_r),
      .s    (st_s),
      .cout (st_cout)
   );

   assign last     = (idx == LAST);
   assign part_nxt = {st_s, part};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (1'b1)
         (state == IDLE): begin
            if (start) state_nxt = ADD;
         end
         (state == ADD): begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         (state == DONE): begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, byte shifting and result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         part      <= '0;
         idx       <= '0;
         carry_r   <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_r <= carry_in;
            part    <= '0;
            idx     <= '0;
            a_msb   <= op_a[W-1];
            b_msb   <= op_b[W-1];
         end else if (state == ADD) begin
            a_sh    <= a_sh >> BYTE_W;
            b_sh    <= b_sh >> BYTE_W;
            carry_r <= st_cout;
            part    <= part_nxt[W-1:BYTE_W];
            idx     <= idx + 1'b1;
            if (last) begin
               result    <= part_nxt;
               carry_out <= st_cout;
               overflow  <= (a_msb == b_msb) &&
                            (st_s[BYTE_W-1] != a_msb);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_byte_adder.sv
// Self-checking bench for serial_byte_adder.
// Arithmetic reference model plus literal directed cases.
module tb_serial_byte_adder;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         carry_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int vectors = 0;
   int miscompares = 0;

   serial_byte_adder #(.NBYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: cycles since accepted start, and W+1-bit sum.
   int           m_cnt = 0;
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;
   logic         m_c = 1'b0;
   logic [W-1:0] m_res = '0;
   logic         m_co = 1'b0;
   logic         m_ov = 1'b0;
   logic [W:0]   m_full;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0;
         m_res = '0;
         m_co  = 1'b0;
         m_ov  = 1'b0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt = 1;
            m_a   = op_a;
            m_b   = op_b;
            m_c   = carry_in;
         end
      end else if (m_cnt == NB + 1) begin
         m_cnt = 0;
      end else begin
         m_cnt = m_cnt + 1;
         if (m_cnt == NB + 1) begin
            m_full = {1'b0, m_a} + {1'b0, m_b} + (W + 1)'(m_c);
            m_res  = m_full[W-1:0];
            m_co   = m_full[W];
            m_ov   = (m_a[W-1] == m_b[W-1]) && (m_res[W-1] != m_a[W-1]);
         end
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("busy", W'(busy), W'(m_cnt != 0));
      chk("done", W'(done), W'(m_cnt == NB + 1));
      chk("result", result, m_res);
      chk("carry_out", W'(carry_out), W'(m_co));
      chk("overflow", W'(overflow), W'(m_ov));
   end

   task automatic run_op(input string nm, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] er, input logic eco,
                         input logic eov);
      int  bcnt;
      bit  seen;
      bcnt = 0;
      seen = 0;
      @(negedge clk); #1;
      op_a = a; op_b = b; carry_in = ci; start = 1'b1;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk); #1;
         if (k == 1) start = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            seen = 1;
            chk({nm, "_lat"}, W'(k), W'(NB + 1));
            chk({nm, "_busy"}, W'(bcnt), W'(NB + 1));
            chk({nm, "_res"}, result, er);
            chk({nm, "_co"}, W'(carry_out), W'(eco));
            chk({nm, "_ov"}, W'(overflow), W'(eov));
         end
      end
      if (!seen) chk({nm, "_timeout"}, '0, W'(1));
      @(negedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '1;
         1: return '0;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit seen;
      int last_k;
      int ndone;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_result", result, '0);
      rst_n = 1'b1;

      run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0,
             32'h0000_0100, 1'b0, 1'b0);
      run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
             32'h0000_0000, 1'b1, 1'b0);
      run_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
      run_op("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0,
             32'h0000_0000, 1'b1, 1'b1);
      run_op("t3c", 32'h1234_5678, 32'h0FED_CBA9, 1'b1,
             32'h2222_2222, 1'b0, 1'b0);

      // Start while busy is ignored.
      @(negedge clk); #1;
      op_a = 32'h11; op_b = 32'h22; carry_in = 1'b0; start = 1'b1;
      seen = 0;
      ndone = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk); #1;
         if (k == 1) start = 1'b0;
         if (k == 2) begin
            start = 1'b1; op_a = '1; op_b = '1;
         end
         if (done) begin
            seen = 1;
            start = 1'b0;
            chk("t4_res", result, 32'h0000_0033);
         end
      end
      if (!seen) chk("t4_timeout", '0, W'(1));
      repeat (3) begin
         @(negedge clk); #1;
         if (done) ndone++;
      end
      chk("t4_idle", W'(busy), '0);
      chk("t4_single", W'(ndone), '0);

      // Asynchronous reset mid-operation.
      @(negedge clk); #1;
      op_a = 32'h10; op_b = 32'h20; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_busy", W'(busy), '0);
      chk("t5_done", W'(done), '0);
      chk("t5_res", result, '0);
      chk("t5_co", W'(carry_out), '0);
      chk("t5_ov", W'(overflow), '0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      run_op("t5_new", 32'h5, 32'h7, 1'b0, 32'h0000_000C, 1'b0, 1'b0);

      // Start held high: one operation every NB+2 edges.
      @(negedge clk); #1;
      op_a = 32'h1; op_b = 32'h1; carry_in = 1'b0; start = 1'b1;
      last_k = -1;
      ndone = 0;
      for (int k = 1; k <= 40 && ndone < 3; k++) begin
         @(negedge clk); #1;
         if (done) begin
            chk("t6_res", result, 32'h0000_0002);
            if (last_k >= 0) chk("t6_gap", W'(k - last_k), W'(NB + 2));
            last_k = k;
            ndone++;
         end
      end
      chk("t6_count", W'(ndone), W'(3));
      start = 1'b0;
      repeat (8) @(negedge clk);

      // Random stimulus, checked every cycle by the model.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         start    = ($urandom_range(0, 3) == 0);
         op_a     = pick();
         op_b     = pick();
         carry_in = $urandom_range(0, 1) == 1;
      end
      start = 1'b0;
      repeat (8) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
